lsu_ld_spec_feedback_unit: RTL
==============================

Name: lsu_ld_spec_feedback_unit

Overview:
- LSU-side producer of the load-speculation feedback toward the renamer's active list (AL).
- Collects RAW-hazard reports from the NUM_REQ load pipes and buffers them in a small pending set.
- Drives at most one feedback per cycle, oldest first by AL age relative to al_rp, onto ld_speculative_feedback_valid/al_idx.
- Drops reports whose AL entry has already graduated or been squashed.

Parameters:
AL_IDX_WIDTH, 6, width of AL index; AL has 2^AL_IDX_WIDTH slots, rp==wp means empty.
NUM_REQ, 2, number of load pipes that can report a hazard per cycle.
DEPTH, 4, pending-entry capacity (must be >= NUM_REQ).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  pipeline flush; discards all pending and incoming reports.
al_rp  in  AL_IDX_WIDTH  AL read (graduate) pointer from renamer.
al_wp  in  AL_IDX_WIDTH  AL write pointer from renamer.
req_valid  in  NUM_REQ  hazard report valid, one bit per load pipe.
req_al_idx  in  NUM_REQ*AL_IDX_WIDTH  AL index of the offending load, packed per pipe.
req_ready  out  1  at least NUM_REQ free pending entries.
ld_speculative_feedback_valid  out  1  feedback valid (registered).
ld_speculative_feedback_al_idx  out  AL_IDX_WIDTH  AL index being reported (registered).
overflow_err  out  1  one-cycle pulse: a request was issued while req_ready=0.

Behaviour:
Reset and derived values:
- Reset (async, rst_n=0): all entries invalid; feedback_valid=0, feedback_al_idx=0, overflow_err=0, req_ready=1. Reset mid-operation loses all pending reports.
- age(x) = (x - al_rp) mod 2^AL_IDX_WIDTH.
- occ = (al_wp - al_rp) mod 2^AL_IDX_WIDTH.
- An index is live iff age < occ. Both are evaluated combinationally with the current-cycle pointers.

Each cycle (no flush):
- Candidate set = stored valid entries + incoming req_valid entries. Incoming entries are accepted only when req_ready=1.
- Non-live candidates are dropped.
- Candidates with equal al_idx are merged into one.
- If any live candidate exists: register the minimum-age candidate onto the feedback outputs next edge, with valid=1, and remove it from the set. Otherwise feedback_valid=0 next edge.
- Remaining live candidates are stored. Storage order is irrelevant; selection is always by age.
- Latency: a request at cycle t with no older competitor appears on the outputs at t+1.
- No back-pressure on the feedback output: the renamer consumes one per cycle unconditionally.
- Staleness of an emitted index after emission is the renamer's concern.

Ready and overflow:
- req_ready = (DEPTH - stored valid count) >= NUM_REQ, computed from registered state only.
- Requests arriving while req_ready=0 are ignored, and overflow_err pulses next cycle.

Flush:
- flush=1: next edge all entries invalid and feedback_valid=0. Same-cycle requests are ignored and do not raise overflow_err.

Boundary cases:
- Wrap-around: age arithmetic is modulo, so idx=63 with rp=62 is older than idx=1. Correct across the pointer wrap.
- Empty AL (rp==wp): everything is non-live and the set drains in one cycle.
- Simultaneous reports: same-cycle reports from different pipes with the same idx produce a single feedback.
- Full set: if all DEPTH entries stay live, throughput is one per cycle and req_ready remains 0 until count <= DEPTH-NUM_REQ.

Test Plan:
1. rp=0, wp=10; pipe0 reports idx 5 at t -> fb_valid=1, idx=5 at t+1; fb_valid=0 at t+2.
2. rp=60, wp=4; pipe0 idx 2 and pipe1 idx 62 at the same cycle -> feedback 62 at t+1, then 2 at t+2 (wrap ordering).
3. rp=0, wp=10; both pipes report idx 7 -> exactly one feedback idx=7; stored count 0 afterward.
4. Report idx 3 (rp=0, wp=8) buffered behind 2; al_rp advances to 4 before it is emitted -> idx 3 never appears on the outputs.
5. Fill 3 stored entries (DEPTH=4) -> req_ready=0. Assert req_valid=01 -> request ignored, overflow_err=1 for one cycle.
6. Pending entries present; flush=1 with a same-cycle request -> next cycle fb_valid=0, req_ready=1, overflow_err=0. Also assert rst_n low mid-drain -> outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/lsu_ld_spec_feedback_unit.sv
// Load-speculation feedback producer: buffers RAW-hazard reports from the load pipes and
// emits the oldest live AL index (by age relative to al_rp) once per cycle to the renamer.
module lsu_ld_spec_feedback_unit #(
  parameter int AL_IDX_WIDTH = 6,
  parameter int NUM_REQ      = 2,
  parameter int DEPTH        = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [AL_IDX_WIDTH-1:0]         al_rp,
  input  logic [AL_IDX_WIDTH-1:0]         al_wp,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*AL_IDX_WIDTH-1:0] req_al_idx,
  output logic                            req_ready,
  output logic                            ld_speculative_feedback_valid,
  output logic [AL_IDX_WIDTH-1:0]         ld_speculative_feedback_al_idx,
  output logic                            overflow_err
);

  localparam int NC = DEPTH + NUM_REQ;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AL_IDX_WIDTH-1:0] idx_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  idx_t             idx_q [DEPTH];
  idx_t             idx_d [DEPTH];
  logic             fb_valid_q, fb_valid_d;
  idx_t             fb_idx_q, fb_idx_d;
  logic             ovf_q, ovf_d;

  logic [CW-1:0]    count;
  logic             accept;
  idx_t             occ;
  logic [NC-1:0]    candV;
  logic [NC-1:0]    keep;
  idx_t             candIdx [NC];
  idx_t             candAge [NC];
  logic             selFound;
  int               selPos;
  int               wrPtr;

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(valid_q[i]);
    end
  end

  // Ready depends only on registered occupancy so it never combinationally loops back.
  assign req_ready = ((CW'(DEPTH) - count) >= CW'(NUM_REQ));

  always_comb begin
    accept = req_ready && !flush;
    occ    = al_wp - al_rp;

    for (int i = 0; i < DEPTH; i++) begin
      candV[i]   = valid_q[i];
      candIdx[i] = idx_q[i];
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      candV[DEPTH+r]   = req_valid[r] && accept;
      candIdx[DEPTH+r] = req_al_idx[r*AL_IDX_WIDTH +: AL_IDX_WIDTH];
    end

    // Keep live candidates only; a later duplicate of an already-kept index is merged away.
    keep = '0;
    for (int c = 0; c < NC; c++) begin
      candAge[c] = candIdx[c] - al_rp;
      keep[c]    = candV[c] && (candAge[c] < occ);
      for (int j = 0; j < c; j++) begin
        if (keep[j] && (candIdx[j] == candIdx[c])) begin
          keep[c] = 1'b0;
        end
      end
    end

    selFound = 1'b0;
    selPos   = 0;
    for (int c = 0; c < NC; c++) begin
      if (keep[c] && (!selFound || (candAge[c] < candAge[selPos]))) begin
        selFound = 1'b1;
        selPos   = c;
      end
    end

    valid_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_d[i] = idx_q[i];
    end
    wrPtr = 0;
    for (int c = 0; c < NC; c++) begin
      if (keep[c] && !(selFound && (c == selPos)) && (wrPtr < DEPTH)) begin
        valid_d[wrPtr] = 1'b1;
        idx_d[wrPtr]   = candIdx[c];
        wrPtr          = wrPtr + 1;
      end
    end

    fb_valid_d = selFound;
    fb_idx_d   = selFound ? candIdx[selPos] : fb_idx_q;
    ovf_d      = !flush && (|req_valid) && !req_ready;

    if (flush) begin
      valid_d    = '0;
      fb_valid_d = 1'b0;
      fb_idx_d   = fb_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
      end
      fb_valid_q <= 1'b0;
      fb_idx_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= idx_d[i];
      end
      fb_valid_q <= fb_valid_d;
      fb_idx_q   <= fb_idx_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ld_speculative_feedback_valid  = fb_valid_q;
  assign ld_speculative_feedback_al_idx = fb_idx_q;
  assign overflow_err                   = ovf_q;

endmodule
